pc_sequencer: RTL

// - Owns the fetch PC of the 5-stage pipeline: PC register, next-PC select, fetch handshake to instruction memory.
// - Arbitrates redirect sources (EX branch/jr, ID jump, optional IRQ), load-use stalls and imem wait states.
// - Drives IF/ID enable and flush plus ID/EX flush. Sits between hazard unit, imem port and IF/ID register.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_next_mux.sv | 23 ++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC sequencer: opcodes, next-PC select codes,
// FSM states and the reset/interrupt default addresses.
package pc_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_IRQ = 2'b01;
    localparam logic [1:0] PCSRC_EX  = 2'b10;
    localparam logic [1:0] PCSRC_ID  = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_PEND
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h0000_0080;

    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: picks the sequential, EX redirect, ID jump or interrupt
// target according to the pcsrc code.
module pc_next_mux
    import pc_pkg::*;
(
    input  logic [1:0]  pcsrc,
    input  logic [31:0] pc4,
    input  logic [31:0] ex_target,
    input  logic [31:0] id_target,
    input  logic [31:0] irq_vec,
    output logic [31:0] next_pc
);

    always_comb begin
        case (pcsrc)
            PCSRC_EX:  next_pc = ex_target;
            PCSRC_ID:  next_pc = id_target;
            PCSRC_IRQ: next_pc = irq_vec;
            default:   next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the 5-stage pipeline: PC register, imem handshake FSM,
// redirect arbitration and IF/ID, ID/EX control. Optional IRQ via PCSEQ_IRQ_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter int unsigned STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          id_op,
    input  logic [31:0]         id_pc4,
    input  logic [25:0]         id_jidx,
    input  logic [5:0]          ex_op,
    input  logic                ex_zero,
    input  logic                ex_jr,
    input  logic [31:0]         ex_btarget,
    input  logic [31:0]         ex_rs,
    input  logic                load_use,
    input  logic                imem_ready,
    input  logic                irq,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    output logic [31:0]         pc4_out,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic [1:0]          pcsrc,
    output logic [STALL_CW-1:0] stall_cnt,
    output logic                irq_ack,
    output logic [31:0]         epc
);

    localparam logic [STALL_CW-1:0] STALL_ONE = 1;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] next_pc;
    logic [31:0] ex_target;
    logic [31:0] id_target;
    logic        ex_redir;
    logic        id_jump;
    logic        irq_take;
    logic        redirect;
    logic        hold;
    logic        fetch_active;

    assign ex_redir     = ((ex_op == OP_BEQ) && ex_zero) || ((ex_op == OP_BNE) && !ex_zero) || ex_jr;
    assign id_jump      = (id_op == OP_J);
    assign fetch_active = (state == S_FETCH) || (state == S_WAIT);
    assign ex_target    = ex_jr ? ex_rs : ex_btarget;
    assign id_target    = jump_target(id_pc4, id_jidx);

    assign imem_addr = pc;
    assign pc4_out   = pc + 32'd4;
    assign if_id_en  = fetch_active && imem_ready && !load_use;

`ifdef PCSEQ_IRQ_EN
    logic irq_mask;

    assign irq_take = fetch_active && irq && !irq_mask && !ex_redir;

    // Mask stays set while the request line is held so a level irq is taken once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_ack  <= 1'b0;
            epc      <= '0;
            irq_mask <= 1'b0;
        end else begin
            irq_ack <= irq_take;
            if (irq_take) begin
                epc      <= id_pc4 - 32'd4;
                irq_mask <= 1'b1;
            end else if (!irq) begin
                irq_mask <= 1'b0;
            end
        end
    end
`else
    logic unused_irq;

    assign irq_take   = 1'b0;
    assign irq_ack    = 1'b0;
    assign epc        = '0;
    assign unused_irq = &{1'b0, irq, id_pc4[27:0]};
`endif

    always_comb begin
        pcsrc       = PCSRC_SEQ;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = 1'b0;
        hold        = 1'b0;
        case (state)
            S_BOOT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            S_FETCH, S_WAIT: begin
                if (ex_redir) begin
                    pcsrc       = PCSRC_EX;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    redirect    = 1'b1;
                end else if (irq_take) begin
                    pcsrc       = PCSRC_IRQ;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    redirect    = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                    hold        = 1'b1;
                end else if (id_jump) begin
                    pcsrc       = PCSRC_ID;
                    if_id_flush = 1'b1;
                    redirect    = 1'b1;
                end
            end
            S_PEND: begin
                if_id_flush = imem_ready;
            end
            default: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase
    end

    pc_next_mux u_next_mux (
        .pcsrc     (pcsrc),
        .pc4       (pc4_out),
        .ex_target (ex_target),
        .id_target (id_target),
        .irq_vec   (IRQ_VEC),
        .next_pc   (next_pc)
    );

    // A redirect seen while imem is busy is parked in pend_pc so the live
    // fetch address never changes mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            pend_pc   <= RESET_PC;
            imem_req  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if ((state != S_BOOT) && !if_id_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_ONE;
            case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH, S_WAIT: begin
                    if (imem_ready) begin
                        state <= S_FETCH;
                        if (!hold)
                            pc <= next_pc;
                    end else if (redirect) begin
                        pend_pc <= next_pc;
                        state   <= S_PEND;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_PEND: begin
                    if (imem_ready) begin
                        pc    <= pend_pc;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule
